rfifo_rd_sched: RTL and testbench
=================================

Name: rfifo_rd_sched

Overview:
Read-side scheduler in the SDRAM clock domain that keeps the read FIFO (16-bit write port, 8-bit read port) topped up. It monitors the FIFO write-side fill level, issues fixed-length burst read requests to the SDRAM controller over a req/ack handshake, and forwards returned data beats into the FIFO write port. It walks a circular address window [base, end] and supports start/stop control from the host.

Parameters:
ADDR_W, 24, SDRAM word address width
BURST_LEN, 8, 16-bit beats per read burst (power of 2, 2..256)
FIFO_DEPTH, 512, read FIFO depth in 16-bit words
USEDW_W, 10, width of fifo_wr_usedw (holds 0..FIFO_DEPTH)

Ports:
clk  in  1  SDRAM/FIFO write-side clock
rst_n  in  1  asynchronous active-low reset
rd_start  in  1  one-cycle pulse: latch cfg window, begin scheduling
rd_stop  in  1  one-cycle pulse: finish current burst, then stop
cfg_base_addr  in  ADDR_W  window start, must be BURST_LEN aligned
cfg_end_addr  in  ADDR_W  window last word (inclusive)
fifo_wr_usedw  in  USEDW_W  FIFO words used (write-clock view)
fifo_full  in  1  FIFO full flag
sdram_rd_req  out  1  burst read request
sdram_rd_addr  out  ADDR_W  burst start address, stable while req=1
sdram_rd_ack  in  1  request accepted (one cycle)
sdram_rd_valid  in  1  read data beat valid
sdram_rd_data  in  16  read data beat
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_data  out  16  FIFO write data
busy  out  1  scheduler active (not IDLE)
ovf_err  out  1  sticky: beat arrived while fifo_full or outside BURST

Behaviour:
- Reset (async, rst_n=0): state IDLE; sdram_rd_req=0, sdram_rd_addr=0, fifo_wr_en=0, fifo_wr_data=0, busy=0, ovf_err=0, beat counter=0, stop_pend=0. Reset mid-burst aborts immediately; no further FIFO writes until restarted.
- States: IDLE, CHECK, REQ, BURST.
- IDLE: on rd_start -> latch base/end, cur_addr=cfg_base_addr, stop_pend=0, ovf_err cleared, go CHECK next cycle. rd_stop ignored.
- CHECK: room = FIFO_DEPTH - fifo_wr_usedw. If stop_pend -> IDLE. Else if room >= 2*BURST_LEN (margin covers CDC lag of usedw) -> REQ, asserting sdram_rd_req with sdram_rd_addr=cur_addr registered on entry. Else stay.
- REQ: hold req/addr until sdram_rd_ack=1; in the ack cycle req drops next cycle, beat counter=0, go BURST. rd_stop in REQ sets stop_pend; request is not withdrawn.
- BURST: each sdram_rd_valid: fifo_wr_en=1 and fifo_wr_data=sdram_rd_data on the next clock (1-cycle registered latency), counter+1. When counter reaches BURST_LEN: cur_addr update, -> CHECK. Valid beats in the ack cycle itself are accepted and counted.
- Address update: next = cur_addr + BURST_LEN; if next + BURST_LEN - 1 > end -> next = base (wrap; partial tail bursts never issued). ADDR_W arithmetic, no carry out.
- rd_stop anywhere except IDLE sets stop_pend; honoured only in CHECK, so a burst is never truncated. rd_start while busy is ignored. rd_start and rd_stop in the same IDLE cycle: start wins, stop_pend=0.
- fifo_full during a valid beat: the beat is still written (FIFO drops it) and ovf_err is set. Valid outside BURST/ack cycle: not written, ovf_err set. ovf_err clears only on reset or an accepted rd_start.
- busy = (state != IDLE).
- At most one outstanding request at any time.

Test Plan:
- Reset then rd_start, base=0x000100, end=0x00011F, usedw=0 -> req with addr 0x100; ack + 8 valid beats 0xA000..0xA007 -> 8 fifo_wr_en pulses, data 0xA000..0xA007, each 1 cycle after its beat.
- Continue the same window with usedw=0 -> request addrs 0x108, 0x110, 0x118, then 0x100 (wrap); no addr > 0x118.
- usedw=497 (room 15 < 16) -> no req; drop usedw to 496 -> req next cycle of CHECK.
- rd_stop pulsed at beat 3 of a burst -> remaining 5 beats written, then IDLE, busy=0, no new req.
- fifo_full=1 during beat 2 -> beat still written, ovf_err=1 and sticky; stray valid in CHECK -> no write, ovf_err=1; new rd_start clears it.
- rst_n low during BURST at beat 4 -> all outputs 0 asynchronously; later beats produce no fifo_wr_en.

Source files
------------

// File: rtl/rfifo_rd_sched_if.sv
// ----------------------------------------------------------------------------
// rfifo_rd_sched_if
//   Burst read channel between the read-FIFO scheduler and the SDRAM
//   controller.
//
//   sdram_rd_req    scheduler -> ctrl  burst read request (held until ack)
//   sdram_rd_addr   scheduler -> ctrl  burst start word address
//   sdram_rd_ack    ctrl -> scheduler  request accepted (one-cycle pulse)
//   sdram_rd_valid  ctrl -> scheduler  read data beat valid
//   sdram_rd_data   ctrl -> scheduler  16-bit read data beat
//
//   master: scheduler side, slave: SDRAM controller side.
// ----------------------------------------------------------------------------
interface rfifo_rd_sched_if #(
    parameter int ADDR_W = 24
);
    logic              sdram_rd_req;
    logic [ADDR_W-1:0] sdram_rd_addr;
    logic              sdram_rd_ack;
    logic              sdram_rd_valid;
    logic [15:0]       sdram_rd_data;

    modport master (
        output sdram_rd_req,
        output sdram_rd_addr,
        input  sdram_rd_ack,
        input  sdram_rd_valid,
        input  sdram_rd_data
    );

    modport slave (
        input  sdram_rd_req,
        input  sdram_rd_addr,
        output sdram_rd_ack,
        output sdram_rd_valid,
        output sdram_rd_data
    );
endinterface

// File: rtl/rfifo_rd_sched.sv
// ----------------------------------------------------------------------------
// rfifo_rd_sched
//   Read-side scheduler in the SDRAM clock domain. Keeps the read FIFO
//   (16-bit write port) topped up by issuing fixed-length burst reads over a
//   circular address window [base, end] and forwarding the returned beats
//   into the FIFO write port with one cycle of registered latency.
//
//   Ports:
//     clk             SDRAM / FIFO write-side clock
//     rst_n           asynchronous active-low reset
//     rd_start        pulse: latch cfg window and begin scheduling (IDLE only)
//     rd_stop         pulse: finish the current burst, then return to IDLE
//     cfg_base_addr   window start (BURST_LEN aligned)
//     cfg_end_addr    window last word (inclusive)
//     fifo_wr_usedw   FIFO fill level, write-clock view
//     fifo_full       FIFO full flag
//     sdram           burst read channel (master modport)
//     fifo_wr_en      FIFO write strobe
//     fifo_wr_data    FIFO write data
//     busy            scheduler not in IDLE
//     ovf_err         sticky: beat while FIFO full, or beat outside a burst
// ----------------------------------------------------------------------------
module rfifo_rd_sched #(
    parameter int ADDR_W     = 24,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 512,
    parameter int USEDW_W    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_start,
    input  logic                rd_stop,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [ADDR_W-1:0]   cfg_end_addr,
    input  logic [USEDW_W-1:0]  fifo_wr_usedw,
    input  logic                fifo_full,
    rfifo_rd_sched_if.master    sdram,
    output logic                fifo_wr_en,
    output logic [15:0]         fifo_wr_data,
    output logic                busy,
    output logic                ovf_err
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_M1  = ADDR_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_BURST
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  beat_cnt;
    logic              stop_pend;

    logic              room_ok;
    logic              beat_ok;
    logic              stray;
    logic [ADDR_W-1:0] addr_step;
    logic [ADDR_W-1:0] addr_tail;
    logic [ADDR_W-1:0] addr_next;

    // Require room for two full bursts: usedw is seen with CDC lag, so one
    // burst of margin keeps an in-flight burst from overrunning the FIFO.
    // Evaluated in 32 bits so usedw > FIFO_DEPTH simply reads as "no room".
    assign room_ok = (32'(fifo_wr_usedw) + 32'(2 * BURST_LEN)) <= 32'(FIFO_DEPTH);

    // Beats are accepted in BURST and also in the ack cycle itself, since a
    // controller may return its first beat together with the ack.
    assign beat_ok = sdram.sdram_rd_valid &&
                     ((state == S_BURST) || ((state == S_REQ) && sdram.sdram_rd_ack));
    assign stray   = sdram.sdram_rd_valid && !beat_ok;

    // Wrap to base whenever the next burst would not fit entirely inside the
    // window, so partial tail bursts are never issued.
    assign addr_step = cur_addr + BURST_A;
    assign addr_tail = addr_step + BURST_M1;
    assign addr_next = (addr_tail > end_q) ? base_q : addr_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            base_q              <= '0;
            end_q               <= '0;
            cur_addr            <= '0;
            beat_cnt            <= '0;
            stop_pend           <= 1'b0;
            sdram.sdram_rd_req  <= 1'b0;
            sdram.sdram_rd_addr <= '0;
            fifo_wr_en          <= 1'b0;
            fifo_wr_data        <= '0;
            busy                <= 1'b0;
            ovf_err             <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;

            // Stop requests are only remembered here; they take effect in
            // CHECK so a burst in flight always completes.
            if ((state != S_IDLE) && rd_stop) begin
                stop_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (rd_start) begin
                        base_q    <= cfg_base_addr;
                        end_q     <= cfg_end_addr;
                        cur_addr  <= cfg_base_addr;
                        stop_pend <= 1'b0;
                        ovf_err   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (stop_pend) begin
                        stop_pend <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (room_ok) begin
                        sdram.sdram_rd_req  <= 1'b1;
                        sdram.sdram_rd_addr <= cur_addr;
                        state               <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (sdram.sdram_rd_ack) begin
                        sdram.sdram_rd_req <= 1'b0;
                        beat_cnt           <= CNT_W'(sdram.sdram_rd_valid);
                        state              <= S_BURST;
                    end
                end

                S_BURST: begin
                    if (sdram.sdram_rd_valid) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            cur_addr <= addr_next;
                            state    <= S_CHECK;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Data path and error flag come after the state case so that an
            // error in the rd_start cycle still sets the sticky flag.
            if (beat_ok) begin
                fifo_wr_en   <= 1'b1;
                fifo_wr_data <= sdram.sdram_rd_data;
                if (fifo_full) begin
                    ovf_err <= 1'b1;
                end
            end
            if (stray) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rfifo_rd_sched.sv
// ----------------------------------------------------------------------------
// tb_rfifo_rd_sched
//   Directed bench for rfifo_rd_sched: a vector table for reset and the first
//   burst, followed by hand-written sequences for address walk/wrap, FIFO
//   room threshold, stop, overflow flag and asynchronous reset mid-burst.
// ----------------------------------------------------------------------------
module tb_rfifo_rd_sched;

    localparam int ADDR_W     = 24;
    localparam int BURST_LEN  = 8;
    localparam int FIFO_DEPTH = 512;
    localparam int USEDW_W    = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rd_start;
    logic              rd_stop;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [ADDR_W-1:0] cfg_end_addr;
    logic [USEDW_W-1:0] fifo_wr_usedw;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [15:0]       fifo_wr_data;
    logic              busy;
    logic              ovf_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rfifo_rd_sched_if #(.ADDR_W(ADDR_W)) sd_if ();

    rfifo_rd_sched #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .USEDW_W   (USEDW_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_start     (rd_start),
        .rd_stop      (rd_stop),
        .cfg_base_addr(cfg_base_addr),
        .cfg_end_addr (cfg_end_addr),
        .fifo_wr_usedw(fifo_wr_usedw),
        .fifo_full    (fifo_full),
        .sdram        (sd_if.master),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy),
        .ovf_err      (ovf_err)
    );

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        stop;
        logic [9:0]  usedw;
        logic        ack;
        logic        valid;
        logic [15:0] data;
        logic        e_req;
        logic [23:0] e_addr;
        logic        e_wen;
        logic [15:0] e_wd;
        logic        e_busy;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic r, input logic st, input logic sp,
                                input logic [9:0] uw, input logic ak, input logic vl,
                                input logic [15:0] dt, input logic ereq,
                                input logic [23:0] eaddr, input logic ewen,
                                input logic [15:0] ewd, input logic ebusy,
                                input logic eovf);
        vec_t v;
        v.rst_n = r;    v.start = st;   v.stop = sp;    v.usedw = uw;
        v.ack = ak;     v.valid = vl;   v.data = dt;
        v.e_req = ereq; v.e_addr = eaddr; v.e_wen = ewen; v.e_wd = ewd;
        v.e_busy = ebusy; v.e_ovf = eovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_start             = 1'b0;
        rd_stop              = 1'b0;
        fifo_full            = 1'b0;
        sd_if.sdram_rd_ack   = 1'b0;
        sd_if.sdram_rd_valid = 1'b0;
        sd_if.sdram_rd_data  = '0;
    endtask

    // Waits (bounded) for a request, checks its address, acks it and feeds
    // BURST_LEN beats d0, d0+1, ... Optional: rd_stop with beat stop_at,
    // fifo_full with beat full_at, async reset during beat abort_at.
    task automatic do_burst(input string tag, input logic [23:0] exp_addr,
                            input logic [15:0] d0, input int stop_at,
                            input int full_at, input int abort_at);
        int w;
        bit aborted;
        w = 0;
        aborted = 1'b0;
        while (!sd_if.sdram_rd_req && w < 10) begin
            step();
            w++;
        end
        chk({tag, ".req_seen"}, 32'(sd_if.sdram_rd_req), 32'd1);
        chk({tag, ".req_addr"}, 32'(sd_if.sdram_rd_addr), 32'(exp_addr));
        sd_if.sdram_rd_ack = 1'b1;
        step();
        sd_if.sdram_rd_ack = 1'b0;
        chk({tag, ".req_drop"}, 32'(sd_if.sdram_rd_req), 32'd0);
        for (int i = 0; i < BURST_LEN; i++) begin
            sd_if.sdram_rd_valid = 1'b1;
            sd_if.sdram_rd_data  = d0 + 16'(i);
            rd_stop              = (i == stop_at);
            fifo_full            = (i == full_at);
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk({tag, ".rst_req"},  32'(sd_if.sdram_rd_req),  32'd0);
                chk({tag, ".rst_addr"}, 32'(sd_if.sdram_rd_addr), 32'd0);
                chk({tag, ".rst_wen"},  32'(fifo_wr_en),          32'd0);
                chk({tag, ".rst_wd"},   32'(fifo_wr_data),        32'd0);
                chk({tag, ".rst_busy"}, 32'(busy),                32'd0);
                chk({tag, ".rst_ovf"},  32'(ovf_err),             32'd0);
                step();
                rst_n   = 1'b1;
                aborted = 1'b1;
            end else begin
                step();
                if (aborted) begin
                    chk($sformatf("%s.post_rst_wen%0d", tag, i), 32'(fifo_wr_en), 32'd0);
                    chk($sformatf("%s.post_rst_busy%0d", tag, i), 32'(busy), 32'd0);
                end else begin
                    chk($sformatf("%s.wen%0d", tag, i), 32'(fifo_wr_en), 32'd1);
                    chk($sformatf("%s.wd%0d", tag, i), 32'(fifo_wr_data), 32'(d0 + 16'(i)));
                    chk($sformatf("%s.ovf%0d", tag, i), 32'(ovf_err),
                        32'((full_at >= 0) && (i >= full_at)));
                    chk($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
                end
            end
        end
        sd_if.sdram_rd_valid = 1'b0;
        rd_stop              = 1'b0;
        fifo_full            = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        fifo_wr_usedw = '0;
        cfg_base_addr = 24'h000100;
        cfg_end_addr  = 24'h00011F;
        idle_inputs();

        // rst start stop usedw ack valid data | req addr wen wd busy ovf
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 16'h0,  0, 24'h0,   0, 16'h0,    0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 16'h0,  0, 24'h0,   0, 16'h0,    0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 0, 0, 16'h0,  0, 24'h0,   0, 16'h0,    1, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 16'h0,  1, 24'h100, 0, 16'h0,    1, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 16'h0,  1, 24'h100, 0, 16'h0,    1, 0);
        tbl[5]  = mk(1, 0, 0, 0, 1, 0, 16'h0,  0, 24'h100, 0, 16'h0,    1, 0);
        for (int k = 0; k < 8; k++) begin
            tbl[6 + k] = mk(1, 0, 0, 0, 0, 1, 16'hA000 + 16'(k),
                            0, 24'h100, 1, 16'hA000 + 16'(k), 1, 0);
        end
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 16'h0,  1, 24'h108, 0, 16'hA007, 1, 0);

        #2;
        for (int i = 0; i < 15; i++) begin
            rst_n                = tbl[i].rst_n;
            rd_start             = tbl[i].start;
            rd_stop              = tbl[i].stop;
            fifo_wr_usedw        = tbl[i].usedw;
            sd_if.sdram_rd_ack   = tbl[i].ack;
            sd_if.sdram_rd_valid = tbl[i].valid;
            sd_if.sdram_rd_data  = tbl[i].data;
            step();
            chk($sformatf("v%0d.req", i),  32'(sd_if.sdram_rd_req),  32'(tbl[i].e_req));
            chk($sformatf("v%0d.addr", i), 32'(sd_if.sdram_rd_addr), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d.wen", i),  32'(fifo_wr_en),          32'(tbl[i].e_wen));
            chk($sformatf("v%0d.wd", i),   32'(fifo_wr_data),        32'(tbl[i].e_wd));
            chk($sformatf("v%0d.busy", i), 32'(busy),                32'(tbl[i].e_busy));
            chk($sformatf("v%0d.ovf", i),  32'(ovf_err),             32'(tbl[i].e_ovf));
        end
        idle_inputs();

        // Address walk through the window and wrap back to base.
        do_burst("b108", 24'h108, 16'hB000, -1, -1, -1);
        do_burst("b110", 24'h110, 16'hB100, -1, -1, -1);
        do_burst("b118", 24'h118, 16'hB200, -1, -1, -1);
        do_burst("b100", 24'h100, 16'hB300, -1, -1, -1);

        // Room threshold: 512-497 = 15 < 16 holds off; 496 gives exactly 16.
        fifo_wr_usedw = 10'd497;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("room15.req%0d", i), 32'(sd_if.sdram_rd_req), 32'd0);
            chk($sformatf("room15.busy%0d", i), 32'(busy), 32'd1);
        end
        fifo_wr_usedw = 10'd496;
        step();
        chk("room16.req", 32'(sd_if.sdram_rd_req), 32'd1);
        chk("room16.addr", 32'(sd_if.sdram_rd_addr), 32'h108);
        fifo_wr_usedw = '0;

        // Stop at beat 3: burst completes, then IDLE without a new request.
        do_burst("stop", 24'h108, 16'hC000, 3, -1, -1);
        step();
        chk("stop.busy", 32'(busy), 32'd0);
        chk("stop.req", 32'(sd_if.sdram_rd_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stop.idle_req%0d", i), 32'(sd_if.sdram_rd_req), 32'd0);
        end

        // Overflow flag: full during beat 2, then a stray beat in CHECK.
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        chk("restart.busy", 32'(busy), 32'd1);
        do_burst("full", 24'h100, 16'hD000, -1, 2, -1);
        fifo_wr_usedw        = 10'd497;
        sd_if.sdram_rd_valid = 1'b1;
        sd_if.sdram_rd_data  = 16'hEEEE;
        step();
        sd_if.sdram_rd_valid = 1'b0;
        chk("stray.wen", 32'(fifo_wr_en), 32'd0);
        chk("stray.ovf", 32'(ovf_err), 32'd1);
        step();
        chk("stray.ovf_sticky", 32'(ovf_err), 32'd1);
        rd_stop = 1'b1;
        step();
        rd_stop = 1'b0;
        chk("stray.stop_busy_hold", 32'(busy), 32'd1);
        step();
        chk("stray.stop_idle", 32'(busy), 32'd0);
        chk("stray.ovf_idle", 32'(ovf_err), 32'd1);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        chk("start.ovf_clear", 32'(ovf_err), 32'd0);
        chk("start.busy", 32'(busy), 32'd1);

        // Asynchronous reset during beat 4 of a burst.
        fifo_wr_usedw = '0;
        do_burst("abort", 24'h100, 16'hF000, -1, -1, 4);
        chk("abort.final_req", 32'(sd_if.sdram_rd_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
